// File: rtl/noc_4ph_rx_bridge.sv
// rtl/noc_4ph_rx_bridge.sv - clocked receiver for a 4-phase bundled-data NoC link, packet FIFO, valid/ready out
// Optional MISROUTE_CHK_EN: packets whose dest != MY_ADDR are acked but dropped and counted.
module noc_4ph_rx_bridge #(
  parameter int                    PACKET_WIDTH  = 39,
  parameter int                    ADDR_WIDTH    = 4,
  parameter int                    OP_WIDTH      = 2,
  parameter logic [ADDR_WIDTH-1:0] MY_ADDR       = 4'd0,
  parameter int                    FIFO_DEPTH    = 4,
  localparam int                   PAYLOAD_WIDTH = PACKET_WIDTH - 2*ADDR_WIDTH - OP_WIDTH,
  localparam int                   PTR_WIDTH     = $clog2(FIFO_DEPTH),
  localparam int                   CNT_WIDTH     = PTR_WIDTH + 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_req,
  input  logic [PACKET_WIDTH-1:0]  in_data,
  output logic                     in_ack,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [ADDR_WIDTH-1:0]    out_dest,
  output logic [ADDR_WIDTH-1:0]    out_src,
  output logic [OP_WIDTH-1:0]      out_op,
  output logic [PAYLOAD_WIDTH-1:0] out_payload,
  output logic [CNT_WIDTH-1:0]     out_count
`ifdef MISROUTE_CHK_EN
  ,
  output logic [7:0]               misroute_cnt
`endif
);

`ifdef MISROUTE_CHK_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif

  typedef enum logic {S_IDLE, S_ACK_HI} state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic                    r_req_s1;
  logic                    r_req_s2;
  logic                    r_ack;
  logic                    w_ack_nxt;
  logic [PACKET_WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [PTR_WIDTH-1:0]    r_wptr;
  logic [PTR_WIDTH-1:0]    r_rptr;
  logic [CNT_WIDTH-1:0]    r_count;
  logic                    w_full;
  logic                    w_push;
  logic                    w_pop;
  logic                    w_for_me;
  logic                    w_misroute;
  logic [PACKET_WIDTH-1:0] w_head;

  // Full is taken from the registered count, so a same-edge pop never frees a slot for a push.
  assign w_full   = (r_count == CNT_WIDTH'(FIFO_DEPTH));
  assign w_pop    = out_valid && out_ready;
  assign w_for_me = !CHK_EN || (in_data[PACKET_WIDTH-1 -: ADDR_WIDTH] == MY_ADDR);

  always_comb begin
    w_state_nxt = r_state;
    w_ack_nxt   = r_ack;
    w_push      = 1'b0;
    w_misroute  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_req_s2 && (!w_for_me || !w_full)) begin
          w_push      = w_for_me;
          w_misroute  = !w_for_me;
          w_ack_nxt   = 1'b1;
          w_state_nxt = S_ACK_HI;
        end
      end
      S_ACK_HI: begin
        if (!r_req_s2) begin
          w_ack_nxt   = 1'b0;
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_ack_nxt   = 1'b0;
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_req_s1 <= 1'b0;
      r_req_s2 <= 1'b0;
      r_state  <= S_IDLE;
      r_ack    <= 1'b0;
      r_wptr   <= '0;
      r_rptr   <= '0;
      r_count  <= '0;
    end else begin
      r_req_s1 <= in_req;
      r_req_s2 <= r_req_s1;
      r_state  <= w_state_nxt;
      r_ack    <= w_ack_nxt;
      if (w_push) r_wptr <= r_wptr + PTR_WIDTH'(1);
      if (w_pop)  r_rptr <= r_rptr + PTR_WIDTH'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_WIDTH'(1);
        2'b01:   r_count <= r_count - CNT_WIDTH'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset: validity is tracked entirely by the count and pointers.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= in_data;
  end

`ifdef MISROUTE_CHK_EN
  logic [7:0] r_misroute_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_misroute_cnt <= 8'd0;
    end else if (w_misroute && (r_misroute_cnt != 8'hFF)) begin
      r_misroute_cnt <= r_misroute_cnt + 8'd1;
    end
  end

  assign misroute_cnt = r_misroute_cnt;
`endif

  assign w_head      = r_mem[r_rptr];
  assign in_ack      = r_ack;
  assign out_valid   = (r_count != '0);
  assign out_count   = r_count;
  assign out_dest    = w_head[PACKET_WIDTH-1 -: ADDR_WIDTH];
  assign out_src     = w_head[PACKET_WIDTH-1-ADDR_WIDTH -: ADDR_WIDTH];
  assign out_op      = w_head[PAYLOAD_WIDTH +: OP_WIDTH];
  assign out_payload = w_head[PAYLOAD_WIDTH-1:0];

endmodule

// File: tb/tb_noc_4ph_rx_bridge.sv
// tb/tb_noc_4ph_rx_bridge.sv - self-checking bench for noc_4ph_rx_bridge against a queue model
// Optional MISROUTE_CHK_EN: also checks misroute dropping and counting.
module tb_noc_4ph_rx_bridge;
  localparam int              PW      = 39;
  localparam int              AW      = 4;
  localparam int              OW      = 2;
  localparam int              LW      = PW - 2*AW - OW;
  localparam int              DEPTH   = 4;
  localparam logic [AW-1:0]   MY_ADDR = 4'd0;
`ifdef MISROUTE_CHK_EN
  localparam bit              MIS_EN  = 1'b1;
`else
  localparam bit              MIS_EN  = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          in_req;
  logic [PW-1:0] in_data;
  logic          in_ack;
  logic          out_valid;
  logic          out_ready;
  logic [AW-1:0] out_dest;
  logic [AW-1:0] out_src;
  logic [OW-1:0] out_op;
  logic [LW-1:0] out_payload;
  logic [2:0]    out_count;
`ifdef MISROUTE_CHK_EN
  logic [7:0]    misroute_cnt;
`endif

  int            n_vec = 0;
  int            n_err = 0;
  logic [PW-1:0] exp_q[$];
  int            exp_mis = 0;
  logic          prev_ack = 1'b0;
  bit            rand_ready = 1'b0;

  always #5 clk = ~clk;

  noc_4ph_rx_bridge #(
    .PACKET_WIDTH (PW),
    .ADDR_WIDTH   (AW),
    .OP_WIDTH     (OW),
    .MY_ADDR      (MY_ADDR),
    .FIFO_DEPTH   (DEPTH)
  ) u_dut (
    .clk          (clk),
    .reset        (reset),
    .in_req       (in_req),
    .in_data      (in_data),
    .in_ack       (in_ack),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_dest     (out_dest),
    .out_src      (out_src),
    .out_op       (out_op),
    .out_payload  (out_payload),
    .out_count    (out_count)
`ifdef MISROUTE_CHK_EN
    ,
    .misroute_cnt (misroute_cnt)
`endif
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [PW-1:0] mk(input logic [AW-1:0] d, input logic [AW-1:0] s,
                                       input logic [OW-1:0] op, input logic [LW-1:0] pl);
    return {d, s, op, pl};
  endfunction

  // Reference model: a packet enters the queue when its ack rises, leaves on an accepted pop.
  always @(negedge clk) begin
    if (reset) begin
      exp_q.delete();
      exp_mis  = 0;
      prev_ack = 1'b0;
    end else begin
      if (in_ack && !prev_ack) begin
        if (!MIS_EN || in_data[PW-1 -: AW] == MY_ADDR) exp_q.push_back(in_data);
        else if (exp_mis < 255) exp_mis++;
      end
      prev_ack = in_ack;
      check_eq("count", out_count, exp_q.size());
      check_eq("valid", out_valid, exp_q.size() != 0);
`ifdef MISROUTE_CHK_EN
      check_eq("misroute_cnt", misroute_cnt, exp_mis);
`endif
      if (out_valid && out_ready && exp_q.size() != 0) begin
        check_eq("head", {out_dest, out_src, out_op, out_payload}, exp_q[0]);
        void'(exp_q.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_ready) out_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic req_up(input logic [PW-1:0] pkt);
    in_data = pkt;
    in_req  = 1'b1;
  endtask

  task automatic wait_ack(input logic val, input int budget, output int cyc);
    cyc = 0;
    while (in_ack !== val && cyc < budget) begin
      tick();
      cyc++;
    end
  endtask

  task automatic send(input logic [PW-1:0] pkt);
    int c;
    req_up(pkt);
    wait_ack(1'b1, 60, c);
    check_eq("ack_rise_timeout", in_ack, 1'b1);
    in_req = 1'b0;
    wait_ack(1'b0, 60, c);
    check_eq("ack_fall_timeout", in_ack, 1'b0);
  endtask

  task automatic drain();
    int c = 0;
    rand_ready = 1'b0;
    out_ready  = 1'b1;
    while (out_count != 0 && c < 60) begin
      tick();
      c++;
    end
    check_eq("drain", out_count, 0);
    out_ready = 1'b0;
  endtask

  initial begin
    int c;
    reset     = 1'b1;
    in_req    = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    check_eq("rst_ack", in_ack, 1'b0);
    check_eq("rst_valid", out_valid, 1'b0);
    check_eq("rst_count", out_count, 0);

    // Single packet: 3-cycle ack latency both ways, head visible for exactly one cycle.
    out_ready = 1'b1;
    req_up(mk(4'd0, 4'd1, 2'b01, 29'h1234));
    wait_ack(1'b1, 20, c);
    check_eq("lat_rise", c, 3);
    check_eq("valid_at_ack", out_valid, 1'b1);
    tick();
    check_eq("valid_one_cycle", out_valid, 1'b0);
    in_req = 1'b0;
    wait_ack(1'b0, 20, c);
    check_eq("lat_fall", c, 3);

    // Backpressure: fifth packet held off until one slot is freed.
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(mk(MY_ADDR, 4'(i), 2'(i), 29'(i + 100)));
    check_eq("bp_full", out_count, 4);
    req_up(mk(MY_ADDR, 4'd5, 2'd1, 29'd105));
    wait_ack(1'b1, 20, c);
    check_eq("bp_ack_held", in_ack, 1'b0);
    check_eq("bp_count_held", out_count, 4);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    wait_ack(1'b1, 20, c);
    check_eq("bp_ack_after_pop", in_ack, 1'b1);
    check_eq("bp_count_refill", out_count, 4);
    in_req = 1'b0;
    wait_ack(1'b0, 20, c);
    check_eq("bp_ack_fall", in_ack, 1'b0);

    // Full FIFO, pop on the very edge req_s is first seen high.
    req_up(mk(MY_ADDR, 4'd6, 2'd2, 29'd106));
    tick();
    tick();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check_eq("fp_count_after_pop", out_count, 3);
    check_eq("fp_no_ack_yet", in_ack, 1'b0);
    tick();
    check_eq("fp_count_after_push", out_count, 4);
    check_eq("fp_ack", in_ack, 1'b1);
    in_req = 1'b0;
    wait_ack(1'b0, 20, c);
    check_eq("fp_ack_fall", in_ack, 1'b0);
    drain();

    // Reset while in ACK_HI with two packets buffered.
    send(mk(MY_ADDR, 4'd7, 2'd3, 29'd200));
    req_up(mk(MY_ADDR, 4'd8, 2'd0, 29'd201));
    wait_ack(1'b1, 20, c);
    check_eq("rm_in_ack_hi", in_ack, 1'b1);
    reset  = 1'b1;
    in_req = 1'b0;
    tick();
    reset = 1'b0;
    check_eq("rm_ack", in_ack, 1'b0);
    check_eq("rm_valid", out_valid, 1'b0);
    check_eq("rm_count", out_count, 0);
    out_ready = 1'b1;
    req_up(mk(MY_ADDR, 4'd9, 2'd1, 29'd202));
    wait_ack(1'b1, 20, c);
    check_eq("rm_new_lat", c, 3);
    in_req = 1'b0;
    wait_ack(1'b0, 20, c);
    check_eq("rm_new_fall", in_ack, 1'b0);
    drain();

`ifdef MISROUTE_CHK_EN
    // Misrouted packet is acked but dropped and counted; the next good one is delivered.
    out_ready = 1'b1;
    send(mk(4'd3, 4'd2, 2'd1, 29'h55));
    check_eq("mr_valid", out_valid, 1'b0);
    check_eq("mr_cnt", misroute_cnt, 1);
    send(mk(MY_ADDR, 4'd2, 2'd1, 29'h56));
    drain();
`endif

    // Ordering and pointer wrap: payloads 0..9 with random consumer stalls.
    rand_ready = 1'b1;
    for (int i = 0; i < 10; i++)
      send(mk(MY_ADDR, 4'($urandom), 2'($urandom), 29'(i)));
    drain();

    // Fully random traffic, including arbitrary dest fields.
    rand_ready = 1'b1;
    for (int i = 0; i < 20; i++)
      send(mk(4'($urandom), 4'($urandom), 2'($urandom), 29'($urandom)));
    drain();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/noc_4ph_rx_bridge.md
Name: noc_4ph_rx_bridge

Overview:
- Synchronous receiver at the clocked end of a 4-phase bundled-data NoC link. It is the responder to the NoC router output port that drives a PE, adder or memory endpoint.
- Completes the async req/ack handshake, decodes the packet header and buffers packets in a FIFO.
- Presents packets to clocked endpoint logic over a valid/ready interface.
- Packet format, MSB first: dest addr(4), source addr(4), operation(2), payload.

Parameters:
- PACKET_WIDTH, 39, total packet width.
- ADDR_WIDTH, 4, width of the dest and source fields.
- OP_WIDTH, 2, width of the operation field.
- MY_ADDR, 4'd0, this endpoint's NoC address.
- FIFO_DEPTH, 4, packet buffer entries; power of 2, minimum 2.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- in_req  in  1  4-phase request from NoC; asynchronous, must be synchronized.
- in_data  in  PACKET_WIDTH  bundled data; stable while in_req=1.
- in_ack  out  1  4-phase acknowledge, registered.
- out_valid  out  1  FIFO head valid.
- out_ready  in  1  consumer accepts head.
- out_dest  out  ADDR_WIDTH  head packet [38:35].
- out_src  out  ADDR_WIDTH  head packet [34:31].
- out_op  out  OP_WIDTH  head packet [30:29].
- out_payload  out  PACKET_WIDTH-2*ADDR_WIDTH-OP_WIDTH  head packet [28:0].
- out_count  out  $clog2(FIFO_DEPTH)+1  current occupancy.

Behaviour:
- Reset: in_ack=0, out_valid=0, out_count=0, FIFO pointers=0, FSM=IDLE, sync flops=0.
- A reset mid-handshake drops in_ack to 0 and discards all buffered packets.
- in_req passes through a 2-flop synchronizer; req_s is the second flop's output.
- FSM has two states.
  - IDLE: if req_s=1 and not full, then on that edge write in_data to FIFO, set in_ack<=1 and go to ACK_HI. If full, hold in_ack=0 (backpressure).
  - ACK_HI: wait for req_s=0, then set in_ack<=0 and go to IDLE.
  - Each packet is written exactly once per 4-phase cycle.
- Latency:
  - in_req rise at edge 0 gives req_s=1 after edge 2.
  - Write and in_ack=1 occur at edge 3.
  - out_valid=1 at edge 3 if the FIFO was empty. There is no bypass.
  - Minimum cycle per packet is about 6 clocks.
- Output handshake:
  - Pop occurs when out_valid && out_ready.
  - Head fields are combinational from the FIFO read slot and stable while out_valid && !out_ready.
- Simultaneous push and pop:
  - Non-full: count unchanged, both pointers advance.
  - Full: the push is not allowed that cycle because full is evaluated on the registered count. The pop proceeds and the push occurs on a later edge.
- Pointers wrap modulo FIFO_DEPTH; full when count==FIFO_DEPTH, empty when count==0.
- Header decode is a pure field slice. No check against MY_ADDR unless MISROUTE_CHK_EN is defined.

Optional Feature:
- Macro name: MISROUTE_CHK_EN.
- Defined:
  - A packet with dest != MY_ADDR is still acknowledged (full handshake) but not written to the FIFO.
  - Port misroute_cnt out 8 increments, saturating at 255, and resets to 0.
  - Acking a misrouted packet does not require FIFO space.
- Undefined:
  - All packets are buffered regardless of dest.
  - The misroute_cnt port is absent.

Test Plan:
- Single packet: in_data = dest 0, src 1, op 2'b01, payload 29'h1234, MY_ADDR=0, out_ready=1.
  - in_ack rises 3 clocks after in_req.
  - out_valid for 1 cycle with out_src=1, out_op=1, out_payload=0x1234.
  - in_ack falls 3 clocks after in_req falls.
- Backpressure: out_ready=0, send 5 packets with FIFO_DEPTH=4.
  - out_count=4.
  - 5th in_ack stays 0.
  - Raising out_ready for 1 cycle lets the 5th be acked, with out_count back to 4.
- Ordering and wrap: stream 10 packets with payload 0..9 and random out_ready.
  - Outputs are 0..9 in order with no loss or duplicates.
- Full with simultaneous pop: FIFO full, pop on the same edge req_s=1.
  - That edge: count becomes 3 and no write occurs.
  - Next edge: write, count=4, in_ack=1.
- Reset mid-handshake: assert reset while in ACK_HI with 2 packets buffered.
  - in_ack=0, out_valid=0, out_count=0.
  - New handshake then completes normally.
- MISROUTE_CHK_EN: send dest=3 with MY_ADDR=0.
  - Full 4-phase ack completes.
  - out_valid stays 0, misroute_cnt=1.
  - A following dest=0 packet is delivered.
